// File: rtl/apb_uart_pkg.sv
// apb_uart shared definitions: register map, bit positions, FSM states.
package apb_uart_pkg;

  localparam logic [5:0] ADDR_CR   = 6'h04;
  localparam logic [5:0] ADDR_DATA = 6'h08;
  localparam logic [5:0] ADDR_SR   = 6'h0C;
  localparam logic [5:0] ADDR_BRGR = 6'h10;
  localparam logic [5:0] ADDR_IMR  = 6'h14;

  localparam int CR_RSTRX  = 0;
  localparam int CR_RSTTX  = 1;
  localparam int CR_RXEN   = 4;
  localparam int CR_TXEN   = 6;
  localparam int CR_PAREN  = 9;
  localparam int CR_PARODD = 10;

  localparam int SR_RXRDY   = 0;
  localparam int SR_TXRDY   = 1;
  localparam int SR_TXEMPTY = 2;
  localparam int SR_OVRE    = 3;
  localparam int SR_PARE    = 5;
  localparam int SR_FRAME   = 6;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP
  } rx_state_e;

  function automatic logic [15:0] eff_cd(input logic [15:0] cd);
    return (cd < 16'd4) ? 16'd4 : cd;
  endfunction

endpackage

// File: rtl/apb_uart_if.sv
// APB bus bundle for the uart peripheral.
interface apb_uart_if;
  logic        psel;
  logic        pwrite;
  logic        penable;
  logic [5:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (
    output psel, pwrite, penable, paddr, pwdata,
    input  prdata
  );

  modport slave (
    input  psel, pwrite, penable, paddr, pwdata,
    output prdata
  );
endinterface

// File: rtl/apb_uart_rx_core.sv
// uart receiver: input synchronizer, mid-bit sampling FSM.
module uart_rx_core
  import apb_uart_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_i,
  input  logic        en,
  input  logic        paren,
  input  logic        parodd,
  input  logic        abort,
  input  logic [15:0] cd,
  output logic        done,
  output logic [7:0]  data,
  output logic        frame_err,
  output logic        par_err
);

  logic        s1, s2, prev;
  rx_state_e   state;
  logic [15:0] cnt;
  logic [2:0]  bitn;
  logic [7:0]  shift;
  logic        par_bit;
  logic        paren_l, parodd_l;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= rx_i;
      s2   <= s1;
      prev <= s2;
    end
  end

  // cnt is reloaded at every sample so a new divider applies per bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bitn      <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      paren_l   <= 1'b0;
      parodd_l  <= 1'b0;
      done      <= 1'b0;
      data      <= '0;
      frame_err <= 1'b0;
      par_err   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= RX_IDLE;
      end else begin
        unique case (state)
          RX_IDLE: begin
            if (en && prev && !s2) begin
              state    <= RX_START;
              cnt      <= {1'b0, cd[15:1]} - 16'd1;
              paren_l  <= paren;
              parodd_l <= parodd;
            end
          end
          RX_START: begin
            if (cnt != 16'd0) begin
              cnt <= cnt - 16'd1;
            end else if (s2) begin
              state <= RX_IDLE;
            end else begin
              state <= RX_DATA;
              cnt   <= cd - 16'd1;
              bitn  <= '0;
            end
          end
          RX_DATA: begin
            if (cnt != 16'd0) begin
              cnt <= cnt - 16'd1;
            end else begin
              shift <= {s2, shift[7:1]};
              bitn  <= bitn + 3'd1;
              cnt   <= cd - 16'd1;
              if (bitn == 3'd7)
                state <= paren_l ? RX_PAR : RX_STOP;
            end
          end
          RX_PAR: begin
            if (cnt != 16'd0) begin
              cnt <= cnt - 16'd1;
            end else begin
              par_bit <= s2;
              cnt     <= cd - 16'd1;
              state   <= RX_STOP;
            end
          end
          RX_STOP: begin
            if (cnt != 16'd0) begin
              cnt <= cnt - 16'd1;
            end else begin
              done      <= 1'b1;
              data      <= shift;
              frame_err <= !s2;
              par_err   <= paren_l &&
                           (par_bit != ((^shift) ^ parodd_l));
              state     <= RX_IDLE;
            end
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/apb_uart.sv
// APB uart top: register file, tx path, rx core instance.
module apb_uart
  import apb_uart_pkg::*;
#(
  parameter int DEFAULT_CD = 217
) (
  input  logic       pclk_i,
  input  logic       preset_n_i,
  apb_uart_if.slave  bus,
  input  logic       uart_rx_i,
  output logic       interrupt_o,
  output logic       uart_tx_o
);

  logic        wr, rd;
  logic        wr_cr, wr_sr, wr_brgr, wr_imr, thr_wr, rd_rhr;
  logic        rst_rx, rst_tx, sr_clr;
  logic        rxen, txen, paren, parodd;
  logic [15:0] brgr, cd;
  logic [6:0]  imr, sr;
  logic [7:0]  rhr, thr;
  logic        rxrdy, ovre, pare, frame, txempty, thr_full;
  logic [31:0] rdata, cr_val;
  logic        rx_done, rx_ferr, rx_perr;
  logic [7:0]  rx_data;
  logic        unused_ok;

  tx_state_e   tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bitn;
  logic [7:0]  tx_shift;
  logic        tx_par, tx_paren;
  logic        stop_end, tx_empty_set;

  assign wr      = bus.psel & bus.penable & bus.pwrite;
  assign rd      = bus.psel & bus.penable & !bus.pwrite;
  assign wr_cr   = wr && (bus.paddr == ADDR_CR);
  assign wr_sr   = wr && (bus.paddr == ADDR_SR);
  assign wr_brgr = wr && (bus.paddr == ADDR_BRGR);
  assign wr_imr  = wr && (bus.paddr == ADDR_IMR);
  assign thr_wr  = wr && (bus.paddr == ADDR_DATA);
  assign rd_rhr  = rd && (bus.paddr == ADDR_DATA);
  assign rst_rx  = wr_cr & bus.pwdata[CR_RSTRX];
  assign rst_tx  = wr_cr & bus.pwdata[CR_RSTTX];
  assign sr_clr  = wr_sr & bus.pwdata[0];
  assign cd      = eff_cd(brgr);

  assign unused_ok = ^bus.pwdata[31:16];

  assign sr = {frame, pare, 1'b0, ovre,
               txempty, !thr_full, rxrdy};
  assign cr_val = {21'd0, parodd, paren, 2'd0,
                   txen, 1'b0, rxen, 4'd0};
  assign interrupt_o = |(sr & imr);
  assign bus.prdata  = rdata;

  always_comb begin
    rdata = '0;
    if (bus.psel && !bus.pwrite) begin
      case (bus.paddr)
        ADDR_CR:   rdata = cr_val;
        ADDR_DATA: rdata = {24'd0, rhr};
        ADDR_SR:   rdata = {25'd0, sr};
        ADDR_BRGR: rdata = {16'd0, brgr};
        ADDR_IMR:  rdata = {25'd0, imr};
        default:   rdata = '0;
      endcase
    end
  end

  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      rxen   <= 1'b1;
      txen   <= 1'b1;
      paren  <= 1'b0;
      parodd <= 1'b0;
      brgr   <= 16'(DEFAULT_CD);
      imr    <= '0;
    end else begin
      if (wr_cr) begin
        rxen   <= bus.pwdata[CR_RXEN];
        txen   <= bus.pwdata[CR_TXEN];
        paren  <= bus.pwdata[CR_PAREN];
        parodd <= bus.pwdata[CR_PARODD];
      end
      if (wr_brgr) brgr <= bus.pwdata[15:0];
      if (wr_imr)  imr  <= bus.pwdata[6:0];
    end
  end

  uart_rx_core u_rx (
    .clk       (pclk_i),
    .rst_n     (preset_n_i),
    .rx_i      (uart_rx_i),
    .en        (rxen),
    .paren     (paren),
    .parodd    (parodd),
    .abort     (rst_rx),
    .cd        (cd),
    .done      (rx_done),
    .data      (rx_data),
    .frame_err (rx_ferr),
    .par_err   (rx_perr)
  );

  // set beats clear on every sticky flag
  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      rhr   <= '0;
      rxrdy <= 1'b0;
      ovre  <= 1'b0;
      pare  <= 1'b0;
      frame <= 1'b0;
    end else begin
      if (rx_done) rhr <= rx_data;
      if (rst_rx)       rxrdy <= 1'b0;
      else if (rx_done) rxrdy <= 1'b1;
      else if (rd_rhr)  rxrdy <= 1'b0;
      if (rx_done && rxrdy) ovre  <= 1'b1;
      else if (sr_clr)      ovre  <= 1'b0;
      if (rx_done && rx_perr) pare <= 1'b1;
      else if (sr_clr)        pare <= 1'b0;
      if (rx_done && rx_ferr) frame <= 1'b1;
      else if (sr_clr)        frame <= 1'b0;
    end
  end

  assign stop_end = (tx_state == TX_STOP) && (tx_cnt == 16'd0);
  assign tx_empty_set = stop_end && !thr_full && !rst_tx;

  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      txempty <= 1'b0;
    end else if (tx_empty_set) begin
      txempty <= 1'b1;
    end else if (sr_clr || thr_wr) begin
      txempty <= 1'b0;
    end
  end

  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bitn  <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_paren <= 1'b0;
      thr      <= '0;
      thr_full <= 1'b0;
      uart_tx_o <= 1'b1;
    end else if (rst_tx) begin
      tx_state  <= TX_IDLE;
      thr_full  <= 1'b0;
      uart_tx_o <= 1'b1;
    end else begin
      if (thr_wr && !thr_full) begin
        thr      <= bus.pwdata[7:0];
        thr_full <= 1'b1;
      end
      unique case (tx_state)
        TX_IDLE: begin
          if (txen && thr_full) begin
            tx_shift  <= thr;
            tx_par    <= (^thr) ^ parodd;
            tx_paren  <= paren;
            thr_full  <= 1'b0;
            tx_cnt    <= cd - 16'd1;
            tx_state  <= TX_START;
            uart_tx_o <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt != 16'd0) begin
            tx_cnt <= tx_cnt - 16'd1;
          end else begin
            tx_state  <= TX_DATA;
            tx_bitn   <= '0;
            tx_cnt    <= cd - 16'd1;
            uart_tx_o <= tx_shift[0];
          end
        end
        TX_DATA: begin
          if (tx_cnt != 16'd0) begin
            tx_cnt <= tx_cnt - 16'd1;
          end else begin
            tx_cnt <= cd - 16'd1;
            if (tx_bitn == 3'd7) begin
              tx_state  <= tx_paren ? TX_PAR : TX_STOP;
              uart_tx_o <= tx_paren ? tx_par : 1'b1;
            end else begin
              tx_bitn   <= tx_bitn + 3'd1;
              tx_shift  <= {1'b0, tx_shift[7:1]};
              uart_tx_o <= tx_shift[1];
            end
          end
        end
        TX_PAR: begin
          if (tx_cnt != 16'd0) begin
            tx_cnt <= tx_cnt - 16'd1;
          end else begin
            tx_cnt    <= cd - 16'd1;
            tx_state  <= TX_STOP;
            uart_tx_o <= 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt != 16'd0) begin
            tx_cnt <= tx_cnt - 16'd1;
          end else if (txen && thr_full) begin
            tx_shift  <= thr;
            tx_par    <= (^thr) ^ parodd;
            tx_paren  <= paren;
            thr_full  <= 1'b0;
            tx_cnt    <= cd - 16'd1;
            tx_state  <= TX_START;
            uart_tx_o <= 1'b0;
          end else begin
            tx_state <= TX_IDLE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_uart.sv
// Directed bench for apb_uart: registers, tx/rx frames, error flags.
module tb_apb_uart;

  logic pclk = 1'b0;
  logic preset_n;
  logic uart_rx;
  logic interrupt;
  logic uart_tx;
  longint cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  apb_uart_if bus ();

  apb_uart #(.DEFAULT_CD(217)) dut (
    .pclk_i      (pclk),
    .preset_n_i  (preset_n),
    .bus         (bus.slave),
    .uart_rx_i   (uart_rx),
    .interrupt_o (interrupt),
    .uart_tx_o   (uart_tx)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apb_wr(input logic [5:0] a,
                        input logic [31:0] d);
    @(negedge pclk);
    bus.psel = 1'b1; bus.pwrite = 1'b1;
    bus.paddr = a; bus.pwdata = d; bus.penable = 1'b0;
    @(negedge pclk);
    bus.penable = 1'b1;
    @(negedge pclk);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic rd_chk(input string tag,
                        input logic [5:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    @(negedge pclk);
    bus.psel = 1'b1; bus.pwrite = 1'b0;
    bus.paddr = a; bus.penable = 1'b0;
    @(negedge pclk);
    bus.penable = 1'b1;
    #1 d = bus.prdata;
    @(negedge pclk);
    bus.psel = 1'b0; bus.penable = 1'b0;
    chk(tag, d, exp);
  endtask

  task automatic wait_tx_start(output longint c0);
    int n = 0;
    while (uart_tx !== 1'b0 && n < 1000) begin
      @(negedge pclk);
      n++;
    end
    chk("tx_start_seen", {31'd0, uart_tx}, 32'd0);
    c0 = cyc;
  endtask

  task automatic tx_sample(input longint c0, input int cd,
                           input int from, input int to,
                           output logic [31:0] cap);
    cap = '0;
    for (int k = from; k <= to; k++) begin
      while (cyc < c0 + longint'(k * cd + cd / 2))
        @(negedge pclk);
      cap[k] = uart_tx;
    end
  endtask

  task automatic rx_send(input logic [10:0] bits,
                         input int n, input int cd);
    for (int i = 0; i < n; i++) begin
      uart_rx = bits[i];
      repeat (cd) @(negedge pclk);
    end
    uart_rx = 1'b1;
    repeat (5) @(negedge pclk);
  endtask

  initial begin
    longint c0;
    logic [31:0] cap;
    int n;

    preset_n = 1'b0;
    uart_rx = 1'b1;
    bus.psel = 1'b0; bus.pwrite = 1'b0; bus.penable = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;
    repeat (3) @(negedge pclk);
    chk("rst_tx", {31'd0, uart_tx}, 32'd1);
    chk("rst_irq", {31'd0, interrupt}, 32'd0);
    chk("rst_prdata", bus.prdata, 32'd0);
    preset_n = 1'b1;
    repeat (2) @(negedge pclk);
    rd_chk("rst_sr", 6'h0C, 32'h02);
    rd_chk("rst_cr", 6'h04, 32'h50);
    rd_chk("rst_brgr", 6'h10, 32'd217);
    rd_chk("rst_imr", 6'h14, 32'h00);
    rd_chk("unmapped_rd", 6'h3C, 32'h00);

    // tx 0x93 at 217 cycles per bit
    apb_wr(6'h14, 32'h05);
    rd_chk("imr_rb", 6'h14, 32'h05);
    apb_wr(6'h08, 32'h93);
    wait_tx_start(c0);
    tx_sample(c0, 217, 0, 9, cap);
    chk("tx_93_bits", {22'd0, cap[9:0]}, {22'd0, 10'b1100100110});
    while (cyc < c0 + 10 * 217 + 3) @(negedge pclk);
    chk("tx_idle_hi", {31'd0, uart_tx}, 32'd1);
    chk("txempty_irq", {31'd0, interrupt}, 32'd1);
    rd_chk("sr_txempty", 6'h0C, 32'h06);
    apb_wr(6'h0C, 32'h1);
    chk("irq_cleared", {31'd0, interrupt}, 32'd0);
    rd_chk("sr_after_clr", 6'h0C, 32'h02);

    // rx 0x55
    rx_send(11'b00_1010101010, 10, 217);
    rd_chk("sr_rxrdy", 6'h0C, 32'h03);
    chk("rx_irq", {31'd0, interrupt}, 32'd1);
    rd_chk("rhr_55", 6'h08, 32'h55);
    rd_chk("sr_rx_read", 6'h0C, 32'h02);
    chk("rx_irq_off", {31'd0, interrupt}, 32'd0);

    // overrun: 0x0F then 0xC1 without a read
    rx_send(11'b00_1000011110, 10, 217);
    rx_send(11'b00_1110000010, 10, 217);
    rd_chk("sr_ovre", 6'h0C, 32'h0B);
    rd_chk("rhr_c1", 6'h08, 32'hC1);
    rd_chk("sr_ovre_kept", 6'h0C, 32'h0A);
    apb_wr(6'h0C, 32'h1);
    rd_chk("sr_ovre_clr", 6'h0C, 32'h02);

    // even parity: 0x55 with wrong parity bit, then bad stop
    apb_wr(6'h04, 32'h250);
    rd_chk("cr_par", 6'h04, 32'h250);
    rx_send(11'b11010101010, 11, 217);
    rd_chk("sr_pare", 6'h0C, 32'h23);
    rd_chk("rhr_par55", 6'h08, 32'h55);
    rx_send(11'b00000000000, 11, 217);
    rd_chk("sr_frame", 6'h0C, 32'h63);
    apb_wr(6'h0C, 32'h1);
    rd_chk("sr_err_clr", 6'h0C, 32'h03);
    rd_chk("rhr_00", 6'h08, 32'h00);

    // short low pulse is a false start
    apb_wr(6'h04, 32'h50);
    uart_rx = 1'b0;
    repeat (50) @(negedge pclk);
    uart_rx = 1'b1;
    repeat (400) @(negedge pclk);
    rd_chk("sr_glitch", 6'h0C, 32'h02);

    // 100-cycle bit period, back-to-back frames, ignored write
    apb_wr(6'h10, 32'd100);
    rd_chk("brgr_rb", 6'h10, 32'd100);
    apb_wr(6'h08, 32'hA5);
    wait_tx_start(c0);
    n = 0;
    while (uart_tx === 1'b0 && n < 1000) begin
      n++;
      @(negedge pclk);
    end
    chk("start_len", n, 32'd100);
    apb_wr(6'h08, 32'h11);
    apb_wr(6'h08, 32'h22);
    rd_chk("sr_thr_full", 6'h0C, 32'h00);
    tx_sample(c0, 100, 1, 29, cap);
    chk("tx_a5_11_bits", {2'b00, cap[29:1], 1'b0},
        {2'b00, 30'b1111111111_1000100010_1101001010} & ~32'd1);
    rd_chk("sr_tx_done", 6'h0C, 32'h06);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_uart.md
Name: apb_uart

Overview:
- Single-clock UART peripheral with an APB slave register interface.
- Transmits and receives 8-bit asynchronous frames: start bit, 8 data bits LSB-first, optional parity bit, 1 stop bit.
- Provides status flags, a maskable level interrupt and a programmable bit-period divider.
- Sits on the peripheral APB bus; the interrupt goes to the CPU interrupt controller.

Parameters:
- DEFAULT_CD, 217, reset value of BRGR: pclk cycles per bit (25 MHz / 115200).

Ports:
- pclk_i  in  1  single system/APB clock.
- preset_n_i  in  1  reset; asynchronous, active-low.
- psel_i  in  1  APB select.
- pwrite_i  in  1  APB write (1) / read (0).
- penable_i  in  1  APB access phase.
- paddr_i  in  6  byte address.
- pwdata_i  in  32  write data.
- prdata_o  out  32  read data.
- uart_rx_i  in  1  serial input, asynchronous to pclk_i.
- interrupt_o  out  1  level interrupt.
- uart_tx_o  out  1  serial output, idles high.

Behaviour:
- APB (no wait states):
  - Write takes effect on the pclk_i edge where psel_i & penable_i & pwrite_i.
  - prdata_o is combinational from paddr_i while psel_i & !pwrite_i; it is 0 otherwise.
  - Read side effects occur only in the access phase.
  - Unmapped addresses read 0; writes to them are ignored.
- Registers:
  - 0x04 CR (R/W, reset 0x50):
    - [0] RSTRX: write-1 pulse; aborts the receiver and clears RXRDY.
    - [1] RSTTX: write-1 pulse; aborts transmission, empties THR, forces tx=1.
    - [4] RXEN, [6] TXEN.
    - [9] PAREN, [10] PARODD (0 = even parity).
    - Bits 0 and 1 always read 0.
  - 0x08 write = THR; read = RHR[7:0]. Reading RHR clears RXRDY.
  - 0x0C SR (read):
    - [0] RXRDY, [1] TXRDY (level: THR free), [2] TXEMPTY (sticky).
    - [3] OVRE, [5] PARE, [6] FRAME.
    - Writing with pwdata[0]=1 clears bits 2, 3, 5 and 6. Reset value 0x02.
  - 0x10 BRGR [15:0] CD, cycles per bit, reset DEFAULT_CD. Values <4 behave as 4.
  - 0x14 IMR [6:0] (R/W, reset 0).
- Outputs at reset: uart_tx_o=1, interrupt_o=0, prdata_o=0; both state machines IDLE.
- interrupt_o = |(SR[6:0] & IMR[6:0]), driven from registered state.
- TX path:
  - A THR write with TXRDY=1 loads the holding register and drops TXRDY. A THR write while TXRDY=0 is ignored.
  - A THR write also clears TXEMPTY.
  - With TXEN set and the shifter idle, the holding register moves to the shifter on the next cycle and TXRDY returns to 1.
  - TX FSM: IDLE -> START -> DATA(8) -> [PARITY] -> STOP -> IDLE. Each bit lasts exactly CD cycles.
  - At the end of STOP: if THR holds data, START follows immediately; otherwise TXEMPTY is set.
- RX path:
  - uart_rx_i passes through a 2-flop synchronizer.
  - In IDLE with RXEN set, a falling edge starts the frame. Sample at CD/2; if the line is high, treat it as a false start and return to IDLE.
  - Subsequent bits are sampled every CD cycles at mid-bit: 8 data bits LSB-first, parity if PAREN, then stop.
  - At the stop sample: RHR is loaded and RXRDY is set.
    - OVRE is set if RXRDY was already 1; the new byte overwrites.
    - FRAME is set if stop=0; PARE is set on parity mismatch.
    - The FSM returns to IDLE immediately, ready for the next start.
  - If an RHR read coincides with a new byte load, the load wins (RXRDY=1).
- Simultaneous SR clear and set of the same flag: set wins.
- Clearing RXEN/TXEN mid-frame completes the current frame, then halts.
- A BRGR write takes effect at the next bit boundary.

Decomposition:
- Package apb_uart_pkg holds register offsets (CR 0x04, THR/RHR 0x08, SR 0x0C, BRGR 0x10, IMR 0x14), SR bit positions, CR bit positions and the FSM state enums.
- One natural sub-module: uart_rx_core (synchronizer, receive FSM, bit counter).
- TX path and register file stay in the top level.

Test Plan:
- Reset: read SR=0x02, CR=0x50, BRGR=217, IMR=0; uart_tx_o=1, interrupt_o=0.
- Write IMR=0x05, then THR=0x93 -> uart_tx_o emits 0,1,1,0,0,1,0,0,1,1 at 217 cycles/bit; TXEMPTY=1 and interrupt_o=1 after stop; write SR=0x1 -> interrupt_o=0.
- Drive rx bits 0,1,0,1,0,1,0,1,0,1 at 217 cycles/bit -> RXRDY=1, interrupt_o=1; RHR read returns 0x55 and RXRDY clears.
- Send 0x0F (bits 0,1,1,1,1,0,0,0,0,1) then 0xC1 (bits 0,1,0,0,0,0,0,1,1,1) without reading -> RHR=0xC1, OVRE=1.
- CR=0x250 (even parity): frame 0x55 with parity 1 -> PARE=1; any frame with stop=0 -> FRAME=1; SR write 0x1 clears both.
- rx low pulse of 50 cycles -> no RXRDY. BRGR=100 -> TX bit period 100 cycles. THR write while TXRDY=0 -> ignored.
